// File: rtl/spio_spinnaker_link_sender.sv
// ---------------------------------------------------------------------------
// spio_spinnaker_link_sender
//
// Serialises 72-bit SpiNNaker packets onto a 2-of-7 NRZ SpiNNaker link.
// Each flit toggles exactly two of the seven link wires. The far end answers
// every flit by toggling the (asynchronous) ack wire, and that ack is what
// allows the next flit to go out.
//
// Flit order (nibbles LSB-first): header[3:0], header[7:4], key nibbles 0..7,
// payload nibbles 0..7 (only when header[1] is set), then EOP.
//
// Ports:
//   CLK_IN            system clock, all state on the rising edge
//   RESET_IN          synchronous, active-high reset
//   PKT_DATA_IN[71:0] {payload[31:0], key[31:0], header[7:0]}
//   PKT_VLD_IN        packet offered by the upstream FIFO
//   PKT_RDY_OUT       high when a packet can be captured (registered)
//   SL_DATA_2OF7_OUT  NRZ 2-of-7 link wires (registered)
//   SL_ACK_IN         NRZ link ack, asynchronous to CLK_IN
// ---------------------------------------------------------------------------
module spio_spinnaker_link_sender (
   input  logic        CLK_IN,
   input  logic        RESET_IN,
   input  logic [71:0] PKT_DATA_IN,
   input  logic        PKT_VLD_IN,
   output logic        PKT_RDY_OUT,
   output logic [6:0]  SL_DATA_2OF7_OUT,
   input  logic        SL_ACK_IN
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [6:0] EOP_CODE = 7'b1100000;

   // 2-of-7 toggle mask for one data nibble.
   function automatic logic [6:0] nib_code(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = 7'b0010001;
         4'h1:    code = 7'b0010010;
         4'h2:    code = 7'b0010100;
         4'h3:    code = 7'b0011000;
         4'h4:    code = 7'b0100001;
         4'h5:    code = 7'b0100010;
         4'h6:    code = 7'b0100100;
         4'h7:    code = 7'b0101000;
         4'h8:    code = 7'b1000001;
         4'h9:    code = 7'b1000010;
         4'hA:    code = 7'b1000100;
         4'hB:    code = 7'b1001000;
         4'hC:    code = 7'b0000011;
         4'hD:    code = 7'b0000110;
         4'hE:    code = 7'b0001100;
         default: code = 7'b0001001;
      endcase
      return code;
   endfunction

   state_t      state;
   logic        ack_sync_p0;
   logic        ack_sync_p1;
   logic        ack_prev;
   logic        ack_edge;
   logic        token;
   logic        is_long;
   logic [4:0]  flit_idx;
   logic [71:0] pkt_buf;
   logic        capture;
   logic        emit;
   logic        last_flit;
   logic [6:0]  flit_code;

   assign ack_edge  = ack_sync_p1 ^ ack_prev;
   assign capture   = (state == IDLE) && PKT_VLD_IN && PKT_RDY_OUT;
   assign emit      = (state == SEND) && token;
   // Index 10 (short) or 18 (long) is the EOP slot once all data nibbles are out.
   assign last_flit = (flit_idx == (is_long ? 5'd18 : 5'd10));
   // The buffer shifts down one nibble per emitted flit, so the current
   // nibble is always in the low four bits.
   assign flit_code = last_flit ? EOP_CODE : nib_code(pkt_buf[3:0]);

   // Packet buffer: pure data, loaded on capture and shifted on emission.
   always_ff @(posedge CLK_IN) begin
      if (capture)
         pkt_buf <= PKT_DATA_IN;
      else if (emit)
         pkt_buf <= {4'h0, pkt_buf[71:4]};
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         ack_sync_p0      <= 1'b0;
         ack_sync_p1      <= 1'b0;
         ack_prev         <= 1'b0;
         token            <= 1'b0;
         state            <= IDLE;
         PKT_RDY_OUT      <= 1'b0;
         SL_DATA_2OF7_OUT <= 7'b0000000;
         flit_idx         <= 5'd0;
         is_long          <= 1'b0;
      end else begin
         // Stage p0 -> p1: two-flop synchroniser for the asynchronous ack.
         ack_sync_p0 <= SL_ACK_IN;
         ack_sync_p1 <= ack_sync_p0;
         ack_prev    <= ack_sync_p1;

         // An ack edge wins over a simultaneous emission so no ack is lost.
         token <= ack_edge | (token & ~emit);

         case (state)
            IDLE: begin
               PKT_RDY_OUT <= 1'b1;
               if (capture) begin
                  state       <= SEND;
                  PKT_RDY_OUT <= 1'b0;
                  flit_idx    <= 5'd0;
                  is_long     <= PKT_DATA_IN[1];
               end
            end
            SEND: begin
               if (token) begin
                  SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ flit_code;
                  if (last_flit) begin
                     state       <= IDLE;
                     PKT_RDY_OUT <= 1'b1;
                  end else begin
                     flit_idx <= flit_idx + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spio_spinnaker_link_sender.sv
// ---------------------------------------------------------------------------
// tb_spio_spinnaker_link_sender
//
// Directed and randomised stimulus for the SpiNNaker link sender. A far-end
// process acknowledges each wire change after 23 ns; a monitor records the
// XOR mask of every wire change. Expected masks are derived directly from
// the packet fields (nibble = (pkt >> 4*i) & 15, looked up in the link code
// table) and compared flit by flit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spio_spinnaker_link_sender;

   logic        tb_clk = 1'b0;
   logic        tb_rst = 1'b1;
   logic [71:0] pkt_data = '0;
   logic        pkt_vld = 1'b0;
   logic        pkt_rdy;
   logic [6:0]  sl_data;
   logic        sl_ack;

   logic        ack_auto = 1'b0;   // written only by the far-end process
   logic        ack_man = 1'b0;    // written only by the main sequence
   logic        auto_ack = 1'b0;   // far end answers flits when set

   logic [6:0]  rx_mask[$];        // written only by the monitor
   int          rd_idx = 0;
   int          n_assert = 0;
   int          n_fail = 0;

   logic [6:0]  code_tab [16] = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                                  7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                                  7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                                  7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001};
   localparam logic [6:0] EOP_MASK = 7'b1100000;

   assign sl_ack = ack_auto ^ ack_man;

   always #5 tb_clk = ~tb_clk;

   spio_spinnaker_link_sender dut (
      .CLK_IN           (tb_clk),
      .RESET_IN         (tb_rst),
      .PKT_DATA_IN      (pkt_data),
      .PKT_VLD_IN       (pkt_vld),
      .PKT_RDY_OUT      (pkt_rdy),
      .SL_DATA_2OF7_OUT (sl_data),
      .SL_ACK_IN        (sl_ack)
   );

   // Far end: toggle ack 23 ns after every wire change while enabled.
   initial begin : far_end
      forever begin
         @(sl_data);
         if (auto_ack && !tb_rst) begin
            #23;
            ack_auto = ~ack_auto;
         end
      end
   end

   // Monitor: record each wire change as a toggle mask, 2 ns after the edge.
   initial begin : monitor
      logic [6:0] prev;
      prev = 7'b0;
      forever begin
         @(posedge tb_clk);
         #2;
         if (sl_data !== prev) begin
            if (!tb_rst) rx_mask.push_back(sl_data ^ prev);
            prev = sl_data;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] rand_pkt();
      logic [31:0] r0, r1, r2;
      r0 = $urandom;
      r1 = $urandom;
      r2 = $urandom;
      return {r0, r1, r2[7:0]};
   endfunction

   // Called at a negedge: offer d, wait for capture, then drop valid and
   // drive garbage (which must be ignored).
   task automatic send_pkt(input logic [71:0] d);
      int t;
      t = 0;
      pkt_data = d;
      pkt_vld  = 1'b1;
      while (pkt_rdy !== 1'b1 && t < 5000) begin
         @(negedge tb_clk);
         t++;
      end
      check("rdy_before_capture", pkt_rdy, 1'b1);
      @(negedge tb_clk);
      pkt_vld  = 1'b0;
      pkt_data = rand_pkt();
      check("rdy_after_capture", pkt_rdy, 1'b0);
   endtask

   task automatic wait_rx(input string tag, input int n);
      int t;
      t = 0;
      while (rx_mask.size() < n && t < 20000) begin
         @(negedge tb_clk);
         t++;
      end
      check(tag, rx_mask.size() >= n, 1'b1);
   endtask

   // Compare the next flits of the recorded stream with those of pkt.
   task automatic check_packet(input string tag, input logic [71:0] pkt);
      int         nflits;
      logic [3:0] nib;
      logic [6:0] obs;
      nflits = pkt[1] ? 18 : 10;
      for (int i = 0; i <= nflits; i++) begin
         obs = (rd_idx < rx_mask.size()) ? rx_mask[rd_idx] : 7'bx;
         rd_idx++;
         if (i < nflits) begin
            nib = 4'((pkt >> (4 * i)) & 72'hF);
            check($sformatf("%s_flit%0d", tag, i), obs, code_tab[nib]);
         end else begin
            check($sformatf("%s_eop", tag), obs, EOP_MASK);
         end
      end
   endtask

   initial begin : main
      logic [71:0] pk [26];
      logic [71:0] p;
      logic [6:0]  frozen;
      int          base;
      int          t;

      // Reset with ack held low.
      repeat (3) @(negedge tb_clk);
      check("reset_rdy", pkt_rdy, 1'b0);
      check("reset_wires", sl_data, 7'b0);
      tb_rst = 1'b0;
      @(negedge tb_clk);
      check("rdy_after_release", pkt_rdy, 1'b1);

      // Short packet is captured but waits for the first 0->1 ack.
      p = {32'h0, 32'h1, 8'h00};
      send_pkt(p);
      repeat (20) @(negedge tb_clk);
      check("no_flit_before_ack", sl_data, 7'b0);
      check("no_rx_before_ack", rx_mask.size(), 0);
      check("rdy_held_low", pkt_rdy, 1'b0);
      auto_ack = 1'b1;
      ack_man  = ~ack_man;
      wait_rx("short_flits", 11);
      repeat (5) @(negedge tb_clk);
      check("short_count", rx_mask.size(), 11);
      check_packet("short", p);
      check("short_rdy_back", pkt_rdy, 1'b1);

      // Long packet.
      p = {32'hA5A5A5A5, 32'h0000000F, 8'h02};
      send_pkt(p);
      wait_rx("long_flits", rd_idx + 19);
      repeat (5) @(negedge tb_clk);
      check_packet("long", p);
      check("long_rdy_back", pkt_rdy, 1'b1);

      // Ack withheld after flit 3.
      p = rand_pkt();
      base = rx_mask.size();
      send_pkt(p);
      wait_rx("hold_flit2", base + 2);
      auto_ack = 1'b0;
      wait_rx("hold_flit3", base + 3);
      frozen = sl_data;
      repeat (500) @(negedge tb_clk);
      check("hold_wires_frozen", sl_data, frozen);
      check("hold_count", rx_mask.size(), base + 3);
      check("hold_rdy", pkt_rdy, 1'b0);
      ack_man = ~ack_man;
      repeat (20) @(negedge tb_clk);
      check("hold_one_more", rx_mask.size(), base + 4);
      auto_ack = 1'b1;
      ack_man  = ~ack_man;
      wait_rx("hold_rest", base + (p[1] ? 19 : 11));
      repeat (5) @(negedge tb_clk);
      check_packet("hold", p);

      // Back-to-back packets with valid held high.
      for (int i = 0; i < 26; i++) pk[i] = rand_pkt();
      pkt_vld = 1'b1;
      for (int i = 0; i < 26; i++) begin
         pkt_data = pk[i];
         t = 0;
         while (pkt_rdy !== 1'b1 && t < 5000) begin
            @(negedge tb_clk);
            t++;
         end
         check($sformatf("b2b_rdy%0d", i), pkt_rdy, 1'b1);
         @(negedge tb_clk);
         check($sformatf("b2b_taken%0d", i), pkt_rdy, 1'b0);
      end
      pkt_vld = 1'b0;
      base = rd_idx;
      for (int i = 0; i < 26; i++) base += pk[i][1] ? 19 : 11;
      wait_rx("b2b_flits", base);
      repeat (5) @(negedge tb_clk);
      for (int i = 0; i < 26; i++) check_packet($sformatf("b2b%0d", i), pk[i]);
      check("b2b_no_extra", rx_mask.size(), rd_idx);

      // Reset mid-packet.
      p = rand_pkt();
      base = rx_mask.size();
      send_pkt(p);
      wait_rx("mid_flit4", base + 4);
      auto_ack = 1'b0;
      wait_rx("mid_flit5", base + 5);
      repeat (10) @(negedge tb_clk);
      tb_rst = 1'b1;
      @(negedge tb_clk);
      check("mid_reset_wires", sl_data, 7'b0);
      check("mid_reset_rdy", pkt_rdy, 1'b0);
      ack_man = ack_auto;
      repeat (4) @(negedge tb_clk);
      tb_rst = 1'b0;
      @(negedge tb_clk);
      check("mid_release_rdy", pkt_rdy, 1'b1);
      rd_idx = rx_mask.size();
      auto_ack = 1'b1;
      p = rand_pkt();
      send_pkt(p);
      repeat (30) @(negedge tb_clk);
      check("mid_waits_ack", sl_data, 7'b0);
      check("mid_no_rx", rx_mask.size(), rd_idx);
      ack_man = ~ack_man;
      wait_rx("mid_after_flits", rd_idx + (p[1] ? 19 : 11));
      repeat (5) @(negedge tb_clk);
      check_packet("mid_after", p);
      check("mid_after_rdy", pkt_rdy, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
